// File: rtl/trig_tag_buffer_if.sv
// Tag-stream input and word-serial readout handshake of trig_tag_buffer.
// The slave modport is the buffer's view; the master modport is the producer/reader view.
interface trig_tag_buffer_if;
   logic        in_live;
   logic        in_early_lv1;
   logic [15:0] in_trig_tag;
   logic        rd_ready;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        rd_last;

   modport master (output in_live, in_early_lv1, in_trig_tag, rd_ready,
                   input  rd_valid, rd_data, rd_last);
   modport slave  (input  in_live, in_early_lv1, in_trig_tag, rd_ready,
                   output rd_valid, rd_data, rd_last);
endinterface

// File: rtl/trig_tag_buffer.sv
// Captures lv1b tag frames, checks header / event-ID continuity, buffers whole frames for readout.
// Optional TRIG_TAG_CHKSUM_EN appends an XOR checksum word (word 10) to every stored frame.
module trig_tag_buffer #(
   parameter int FRAMES   = 8,
   parameter int FULL_THR = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   trig_tag_buffer_if.slave         bus,
   output logic                     lv2_full,
   output logic [$clog2(FRAMES):0]  occupancy,
   output logic [15:0]              drop_cnt,
   output logic [15:0]              hdr_err_cnt,
   output logic [15:0]              id_err_cnt,
   output logic [15:0]              abort_cnt
);
   localparam int AW = $clog2(FRAMES);
   localparam int OW = AW + 1;
`ifdef TRIG_TAG_CHKSUM_EN
   localparam int NW = 11;
`else
   localparam int NW = 10;
`endif
   localparam logic [15:0] HDR      = 16'hEEEE;
   localparam logic [OW-1:0] FRAMES_C = OW'(FRAMES);
   localparam logic [OW-1:0] FULL_C   = OW'(FULL_THR);

   typedef enum logic [1:0] {IDLE, CAP, DROP} cap_state_t;

   cap_state_t    state;
   logic [3:0]    widx;
   logic [3:0]    rd_widx;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [9:0]    exp_id;
   logic          id_chk;
   logic [15:0]   chk;
   logic          live_q;
   logic [15:0]   mem [FRAMES][NW];

   logic          live_rise, abort, new_frame, hdr_bad, full;
   logic          commit, free, id_step, id_bad;
   logic [OW-1:0] occ_nxt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   always_comb begin
      live_rise = bus.in_live && !live_q;
      abort     = (state != IDLE) && (!bus.in_live || bus.in_early_lv1);
      new_frame = bus.in_live && bus.in_early_lv1 && ((state == IDLE) || abort);
      hdr_bad   = bus.in_trig_tag != HDR;
      full      = occupancy == FRAMES_C;
      commit    = (state == CAP) && !abort && (widx == 4'd9);
      free      = bus.rd_valid && bus.rd_ready && bus.rd_last;
      // ID is checked for stored frames and for frames dropped only because the FIFO was full
      id_step   = !abort && (widx == 4'd1) && ((state == CAP) || ((state == DROP) && id_chk));
      id_bad    = id_step && (bus.in_trig_tag[9:0] != (live_rise ? 10'd0 : exp_id));
      occ_nxt   = occupancy + OW'(commit) - OW'(free);
   end

   // Capture FSM and event-ID tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         widx   <= '0;
         wr_ptr <= '0;
         id_chk <= 1'b0;
         chk    <= '0;
         live_q <= 1'b0;
         exp_id <= '0;
      end else begin
         live_q <= bus.in_live;
         if (id_step)        exp_id <= bus.in_trig_tag[9:0] + 10'd1;
         else if (live_rise) exp_id <= '0;
         if (commit) wr_ptr <= wr_ptr + AW'(1);
         if (new_frame) begin
            widx   <= 4'd1;
            chk    <= bus.in_trig_tag;
            id_chk <= !hdr_bad;
            state  <= (hdr_bad || full) ? DROP : CAP;
         end else if (abort) begin
            state <= IDLE;
         end else if (state != IDLE) begin
            widx <= widx + 4'd1;
            chk  <= chk ^ bus.in_trig_tag;
            if (widx == 4'd9) state <= IDLE;
         end
      end
   end

   // Frame storage; a partial frame is simply overwritten by the next one at the same wr_ptr
   always_ff @(posedge clk) begin
      if (new_frame && !hdr_bad && !full) mem[wr_ptr][0] <= bus.in_trig_tag;
      if ((state == CAP) && !abort)       mem[wr_ptr][widx] <= bus.in_trig_tag;
`ifdef TRIG_TAG_CHKSUM_EN
      if (commit) mem[wr_ptr][NW-1] <= chk ^ bus.in_trig_tag;
`endif
   end

   // Show-ahead read port, occupancy, back-pressure and error counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr       <= '0;
         rd_widx      <= '0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
         bus.rd_last  <= 1'b0;
         occupancy    <= '0;
         lv2_full     <= 1'b0;
         drop_cnt     <= '0;
         hdr_err_cnt  <= '0;
         id_err_cnt   <= '0;
         abort_cnt    <= '0;
      end else begin
         occupancy <= occ_nxt;
         lv2_full  <= (FRAMES_C - occ_nxt) <= FULL_C;
         if (bus.rd_valid && bus.rd_ready) begin
            if (bus.rd_last) begin
               rd_ptr       <= rd_ptr + AW'(1);
               rd_widx      <= '0;
               bus.rd_valid <= 1'b0;
               bus.rd_last  <= 1'b0;
            end else begin
               rd_widx     <= rd_widx + 4'd1;
               bus.rd_data <= mem[rd_ptr][rd_widx + 4'd1];
               bus.rd_last <= rd_widx == 4'(NW - 2);
            end
         end else if (!bus.rd_valid && ((occupancy != '0) || commit)) begin
            // commit into an empty FIFO: word 0 of that slot is already in place
            bus.rd_valid <= 1'b1;
            bus.rd_data  <= mem[rd_ptr][0];
            bus.rd_last  <= 1'b0;
            rd_widx      <= '0;
         end
         hdr_err_cnt <= sat_inc(live_rise ? 16'h0 : hdr_err_cnt, new_frame && hdr_bad);
         drop_cnt    <= sat_inc(live_rise ? 16'h0 : drop_cnt, new_frame && !hdr_bad && full);
         id_err_cnt  <= sat_inc(live_rise ? 16'h0 : id_err_cnt, id_bad);
         abort_cnt   <= sat_inc(live_rise ? 16'h0 : abort_cnt, abort);
      end
   end
endmodule

// File: tb/tb_trig_tag_buffer.sv
// Scoreboard bench for trig_tag_buffer with a frame-level reference model.
// Define TRIG_TAG_CHKSUM_EN for both DUT and bench to cover the checksum variant.
module tb_trig_tag_buffer;
   localparam int FRAMES   = 8;
   localparam int FULL_THR = 2;
`ifdef TRIG_TAG_CHKSUM_EN
   localparam int NW = 11;
`else
   localparam int NW = 10;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lv2_full;
   logic [3:0]  occupancy;
   logic [15:0] drop_cnt, hdr_err_cnt, id_err_cnt, abort_cnt;
   logic        rd_man = 1'b0;
   logic        rd_rand = 1'b0;
   bit          rd_rand_en = 1'b0;

   trig_tag_buffer_if bus ();
   assign bus.rd_ready = rd_rand_en ? rd_rand : rd_man;

   trig_tag_buffer #(.FRAMES(FRAMES), .FULL_THR(FULL_THR)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .lv2_full(lv2_full), .occupancy(occupancy),
      .drop_cnt(drop_cnt), .hdr_err_cnt(hdr_err_cnt), .id_err_cnt(id_err_cnt),
      .abort_cnt(abort_cnt));

   always #5 clk = ~clk;

   typedef struct packed { logic [15:0] data; logic last; } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   int total = 0, passed = 0;
   // reference model: frames in FIFO = stored - freed; counters and expected ID
   int stored = 0, freed = 0;
   int m_hdr = 0, m_drop = 0, m_id = 0, m_abort = 0, m_exp_id = 0;
   bit pending = 0;

   function automatic void chk(input string name, input int got, input int want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
   endfunction

   // Monitor: pops the scoreboard on every transfer, checks hold-while-stalled and lv2_full
   logic [15:0] hold_data;
   logic        hold_last;
   bit          hold = 0;
   always @(negedge clk) begin
      if (!rst_n) hold = 0;
      else begin
         chk("lv2_full", int'(lv2_full), int'((FRAMES - int'(occupancy)) <= FULL_THR));
         if (hold) begin
            chk("hold_valid", int'(bus.rd_valid), 1);
            chk("hold_data", int'(bus.rd_data), int'(hold_data));
            chk("hold_last", int'(bus.rd_last), int'(hold_last));
         end
         hold      = bus.rd_valid && !bus.rd_ready;
         hold_data = bus.rd_data;
         hold_last = bus.rd_last;
         if (bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL spurious_word: got 0x%0h, expected no word at %0t", bus.rd_data, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rd_data", int'(bus.rd_data), int'(mon_e.data));
               chk("rd_last", int'(bus.rd_last), int'(mon_e.last));
               if (mon_e.last) freed++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2 rd_rand = ($urandom % 2) == 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic drv(input logic e, input logic [15:0] t);
      @(posedge clk);
      #1;
      bus.in_early_lv1 = e;
      bus.in_trig_tag  = t;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 16'($urandom));
   endtask

   task automatic status_check();
      chk("occupancy", int'(occupancy), stored - freed);
      chk("hdr_err_cnt", int'(hdr_err_cnt), m_hdr);
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("id_err_cnt", int'(id_err_cnt), m_id);
      chk("abort_cnt", int'(abort_cnt), m_abort);
   endtask

   // Sends k words of a frame (k < 10 leaves it partial; caller must restart or drop live next)
   task automatic send_frame(input int k, input logic [15:0] hdr, input logic [9:0] id,
                             input int rd_pulse_at, input bit inc_pay);
      logic [15:0] w [NW];
      logic [15:0] x;
      bit store, idchk;
      w[0] = hdr;
      w[1] = inc_pay ? {6'd0, id} : {6'($urandom), id};
      for (int i = 2; i < 10; i++) w[i] = inc_pay ? 16'(i - 1) : 16'($urandom);
      x = '0;
      for (int i = 0; i < 10; i++) x = x ^ w[i];
`ifdef TRIG_TAG_CHKSUM_EN
      w[10] = x;
`endif
      drv(1'b1, w[0]);
      if (rd_pulse_at >= 0) rd_man = (rd_pulse_at == 0);
      status_check();
      if (pending) m_abort++;
      if (hdr != 16'hEEEE) begin
         m_hdr++; store = 0; idchk = 0;
      end else if (stored - freed == FRAMES) begin
         m_drop++; store = 0; idchk = 1;
      end else begin
         store = 1; idchk = 1;
      end
      for (int i = 1; i < k; i++) begin
         drv(1'b0, w[i]);
         if (rd_pulse_at >= 0) rd_man = (rd_pulse_at == i);
      end
      if (k >= 2 && idchk) begin
         if (int'(id) != m_exp_id) m_id++;
         m_exp_id = (int'(id) + 1) % 1024;
      end
      if (k == 10 && store) begin
         for (int i = 0; i < NW; i++) exp_q.push_back('{data: w[i], last: (i == NW - 1)});
         stored++;
      end
      pending = (k < 10);
   endtask

   // Drop live for n cycles (starts offered meanwhile must be ignored), then raise it again
   task automatic live_cycle(input int n);
      @(posedge clk);
      #1;
      bus.in_live = 1'b0;
      bus.in_early_lv1 = 1'b0;
      if (pending) m_abort++;
      pending = 0;
      repeat (n) drv(1'($urandom), 16'hEEEE);
      status_check();
      @(posedge clk);
      #1;
      bus.in_live = 1'b1;
      bus.in_early_lv1 = 1'b0;
      m_hdr = 0; m_drop = 0; m_id = 0; m_abort = 0; m_exp_id = 0;
      idle(1);
   endtask

   task automatic drain();
      int n;
      rd_man = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         idle(1);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      idle(2);
   endtask

   int r, k;
   logic [15:0] hdr;
   logic [9:0]  id;

   initial begin
      bus.in_live = 1'b0;
      bus.in_early_lv1 = 1'b0;
      bus.in_trig_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_valid", int'(bus.rd_valid), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_lv2_full", int'(lv2_full), 0);
      rst_n = 1'b1;
      idle(1);
      bus.in_live = 1'b1;
      idle(2);

      // single frame: latency and ordering
      send_frame(10, 16'hEEEE, 10'd0, -1, 1);
      @(negedge clk);
      chk("rd_valid_T9", int'(bus.rd_valid), 0);
      @(negedge clk);
      chk("rd_valid_T10", int'(bus.rd_valid), 1);
      chk("first_word", int'(bus.rd_data), 16'hEEEE);
      drain();
      status_check();

      // ID continuity: 0, 1, 3
      live_cycle(2);
      rd_man = 1'b0;
      send_frame(10, 16'hEEEE, 10'd0, -1, 0);
      send_frame(10, 16'hEEEE, 10'd1, -1, 0);
      send_frame(10, 16'hEEEE, 10'd3, -1, 0);
      idle(2);
      status_check();
      chk("id_err_one", int'(id_err_cnt), 1);
      drain();

      // fill with reader stalled: lv2_full, drop of frame 9, ID still tracked
      live_cycle(1);
      rd_man = 1'b0;
      for (int f = 0; f < 9; f++) send_frame(10, 16'hEEEE, 10'(f), -1, 0);
      idle(2);
      chk("full_lv2", int'(lv2_full), 1);
      chk("full_drop", int'(drop_cnt), 1);
      drain();
      send_frame(10, 16'hEEEE, 10'd9, -1, 0);
      idle(2);
      status_check();
      chk("after_drop_id", int'(id_err_cnt), 0);
      drain();

      // bad header, then abort by a second start at word 5
      live_cycle(1);
      send_frame(10, 16'h1234, 10'd0, -1, 0);
      idle(2);
      chk("hdr_nothing_stored", int'(occupancy), 0);
      send_frame(5, 16'hEEEE, 10'd0, -1, 0);
      send_frame(10, 16'hEEEE, 10'd1, -1, 0);
      idle(2);
      status_check();
      chk("abort_one", int'(abort_cnt), 1);
      drain();

      // commit and last-word free on the same edge at occupancy 3
      rd_man = 1'b0;
      for (int f = 0; f < 3; f++) send_frame(10, 16'hEEEE, 10'(m_exp_id), -1, 0);
      rd_man = 1'b1;
      idle(9);
      rd_man = 1'b0;
      send_frame(10, 16'hEEEE, 10'(m_exp_id), 9, 0);
      idle(1);
      rd_man = 1'b0;
      chk("occ_commit_free", int'(occupancy), 3);
      drain();

      // randomized traffic with random reader back-pressure
      rd_rand_en = 1;
      for (int f = 0; f < 150; f++) begin
         r = $urandom % 100;
         if (!pending && r < 10) idle($urandom_range(1, 4));
         if (r >= 10 && r < 13) begin
            live_cycle($urandom_range(1, 3));
            continue;
         end
         k   = ($urandom % 100 < 15) ? $urandom_range(1, 9) : 10;
         hdr = ($urandom % 100 < 8) ? 16'($urandom_range(0, 16'hEEED)) : 16'hEEEE;
         id  = ($urandom % 100 < 10) ? 10'($urandom) : 10'(m_exp_id);
         send_frame(k, hdr, id, -1, 0);
      end
      if (pending) send_frame(10, 16'hEEEE, 10'(m_exp_id), -1, 0);
      idle(2);
      status_check();
      rd_rand_en = 0;
      drain();

      // asynchronous reset in the middle of a capture
      rd_man = 1'b0;
      send_frame(10, 16'hEEEE, 10'(m_exp_id), -1, 0);
      send_frame(10, 16'h0BAD, 10'd0, -1, 0);
      send_frame(4, 16'hEEEE, 10'(m_exp_id), -1, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_rd_valid", int'(bus.rd_valid), 0);
      chk("arst_rd_data", int'(bus.rd_data), 0);
      chk("arst_rd_last", int'(bus.rd_last), 0);
      chk("arst_occupancy", int'(occupancy), 0);
      chk("arst_lv2_full", int'(lv2_full), 0);
      chk("arst_hdr_err", int'(hdr_err_cnt), 0);
      chk("arst_counters", int'(drop_cnt | id_err_cnt | abort_cnt), 0);
      exp_q.delete();
      stored = 0; freed = 0; pending = 0;
      m_hdr = 0; m_drop = 0; m_id = 0; m_abort = 0; m_exp_id = 0;
      bus.in_early_lv1 = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      send_frame(10, 16'hEEEE, 10'd0, -1, 0);
      idle(2);
      status_check();
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/trig_tag_buffer.md
Name: trig_tag_buffer

Overview:
- Downstream consumer of the lv1b trigger-tag word stream.
- Captures each 10-word tag frame, which starts on the early-lv1 strobe, and checks the header and the event-ID continuity.
- Stores complete frames in a frame FIFO and serves them word-by-word to the readout over a valid/ready handshake.
- Drives lv2_full back to the lv1b stage when buffer space runs low.

Parameters:
FRAMES, 8, frame slots in the FIFO (power of 2, >=2)
FULL_THR, 2, lv2_full asserts when free slots <= FULL_THR (0 <= FULL_THR < FRAMES)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_live  in  1  run live flag
in_early_lv1  in  1  frame-start strobe; coincides with tag word 0
in_trig_tag  in  16  tag word stream, one word per clock
rd_ready  in  1  readout accepts rd_data
rd_valid  out  1  rd_data holds a stored word
rd_data  out  16  stored tag word
rd_last  out  1  final word of the frame
lv2_full  out  1  back-pressure to lv1b
occupancy  out  log2(FRAMES)+1  committed frames held
drop_cnt  out  16  frames dropped because the FIFO was full
hdr_err_cnt  out  16  frames with word0 != 0xEEEE
id_err_cnt  out  16  event-ID discontinuities
abort_cnt  out  16  frames truncated by a new start or by live falling

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FIFO empty, capture FSM in IDLE, expected ID = 0.
- Frame layout: NW = 10 words. Word 0 is the header (0xEEEE), word 1 [9:0] is the event ID, words 2-9 are payload.
- Capture FSM: IDLE, CAP, DROP.
  - IDLE: when in_early_lv1 is high and in_live is high, the current in_trig_tag is sampled as word 0, with widx = 1.
  - If word 0 != 0xEEEE: hdr_err_cnt++ and go to DROP.
  - Else if occupancy == FRAMES: drop_cnt++ and go to DROP.
  - Else: write word 0 into the slot at wr_ptr and go to CAP.
  - CAP: write in_trig_tag into slot[widx] and increment widx. When word 9 is written, commit: wr_ptr++ and return to IDLE.
  - DROP: consume words without storing until widx == 9, then return to IDLE.
- ID check, applied to every frame with a valid header, whether stored or dropped:
  - At word 1, compare [9:0] against the expected ID. On a mismatch, id_err_cnt++.
  - Expected ID becomes received+1 mod 1024 in both cases.
  - Stored frames with an ID error are kept.
- Abort: in_early_lv1 in CAP or DROP with widx < 10 discards the partial frame, does not commit it, and increments abort_cnt. The same cycle starts a new frame as from IDLE.
  - in_live falling in CAP or DROP also aborts and counts, then goes to IDLE.
  - Starts are ignored while in_live is low.
- Latency: word 0 at cycle T, commit at the edge ending T+9, rd_valid high no earlier than T+10 with an empty FIFO.
- Read port: registered show-ahead. A word transfers when rd_valid && rd_ready. rd_last = 1 on word 9.
  - After the last-word transfer, rd_ptr++ and the slot is freed.
  - rd_data and rd_valid are held stable while rd_ready is low.
- Occupancy: +1 on commit, -1 on frame free. A commit and a free in the same cycle leave it unchanged.
- lv2_full: registered, equal to (FRAMES - occupancy <= FULL_THR).
- Counters: saturate at 0xFFFF. They and the expected ID clear on the rising edge of in_live. FIFO contents are retained across live transitions.

Optional Feature:
- Macro TRIG_TAG_CHKSUM_EN defined:
  - NW = 11. Word 10 is generated internally as the XOR of words 0-9 and stored at commit.
  - rd_last moves to word 10, and the commit edge is unchanged.
- Undefined: NW = 10 and there is no checksum word.

Test Plan:
- Live rise, then one frame EEEE,0000,0001..0008 -> rd_valid at T+10; 10 words read in order; rd_last only on word 9; all error counters 0.
- Three frames with IDs 0,1,3 -> id_err_cnt = 1; all 3 frames stored.
- FRAMES = 8, rd_ready = 0, 9 frames -> lv2_full high once occupancy >= 6; frame 9 dropped with drop_cnt = 1; its ID still tracked, so no id error on frame 10 after draining.
- Frame with word0 = 0x1234 -> hdr_err_cnt = 1, nothing stored. Second in_early_lv1 at word 5 of a frame -> abort_cnt = 1; only the second frame is stored.
- Commit and last-word read in the same cycle at occupancy 3 -> occupancy stays 3. Assert rst_n low mid-capture -> all outputs 0 immediately.
- With TRIG_TAG_CHKSUM_EN -> 11 words per frame; word 10 equals the XOR of words 0-9; rd_last on word 10.
